// File: rtl/pattern_arbiter_pkg.sv
// Shared PPU pattern-fetch definitions: address width, row type, arbiter
// state encoding and requester ids.
package pattern_arbiter_pkg;

  localparam int PAT_ADDR_W = 13;

  typedef logic [31:0] pattern_row_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  localparam logic REQ_SPRITE = 1'b0;
  localparam logic REQ_BG     = 1'b1;

endpackage

// File: rtl/pat_tag_pipe.sv
// Return-tag delay line: one {valid, id} per grant, emerging DEPTH cycles later
// alongside the matching memory data.
module pat_tag_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic id_in,
  input  logic flush,
  output logic pop_valid,
  output logic id_out
);

  logic [DEPTH:1] vld_pipe;
  logic [DEPTH:1] id_pipe;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[1] <= push;
      id_pipe[1]  <= id_in;
      for (int i = 2; i <= DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  // The tag leaving during a flush belongs to a pre-flush request.
  assign pop_valid = vld_pipe[DEPTH] & ~flush;
  assign id_out    = id_pipe[DEPTH];

endmodule

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one.
module sat_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] TOP = W'(MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                     count <= '0;
    else if (clr)                  count <= '0;
    else if (load)                 count <= W'(1);
    else if (inc && count != TOP)  count <= count + W'(1);
  end

endmodule

// File: rtl/pattern_arbiter.sv
// Two-requester pattern-memory arbiter (sprite / background) with lockable
// bursts, round-robin fairness and in-order tagged returns.
module pattern_arbiter
  import pattern_arbiter_pkg::*;
#(
  parameter int LATENCY   = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [1:0]                 req_valid,
  input  logic [1:0][PAT_ADDR_W-1:0] req_addr,
  input  logic [1:0]                 req_lock,
  output logic [1:0]                 req_grant,
  output logic [1:0]                 rsp_avail,
  output logic [31:0]                rsp_data,
  output logic                       mem_rd,
  output logic [PAT_ADDR_W-1:0]      mem_addr,
  input  logic [31:0]                mem_rdata
);

  localparam int            CW   = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

  arb_state_t    state, state_nxt;
  logic          last;
  logic          gnt_id;
  logic [CW-1:0] burst_cnt, cnt_after;
  logic          cnt_clr, cnt_load, cnt_inc;
  logic          pop_valid, pop_id;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  // Round-robin history is deliberately untouched by clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        last <= 1'b1;
    else if (mem_rd)  last <= gnt_id;
  end

  always_comb begin
    state_nxt = state;
    req_grant = '0;
    gnt_id    = REQ_SPRITE;
    cnt_after = burst_cnt;
    cnt_clr   = 1'b0;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    if (reset || clear) begin
      state_nxt = ARB_IDLE;
      cnt_clr   = 1'b1;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (req_valid != 2'b00) begin
            gnt_id            = (req_valid == 2'b11) ? ~last : req_valid[1];
            req_grant[gnt_id] = 1'b1;
            cnt_after         = CW'(1);
            if (req_lock[gnt_id] && !(cnt_after >= MAXC && req_valid[~gnt_id])) begin
              state_nxt = gnt_id ? ARB_OWN1 : ARB_OWN0;
              cnt_load  = 1'b1;
            end
          end
        end
        ARB_OWN0, ARB_OWN1: begin
          gnt_id = (state == ARB_OWN1) ? REQ_BG : REQ_SPRITE;
          if (req_valid[gnt_id]) begin
            req_grant[gnt_id] = 1'b1;
            cnt_after         = (burst_cnt >= MAXC) ? burst_cnt : burst_cnt + CW'(1);
            // Burst ends on lock release, or at the limit if the other side waits.
            if (req_lock[gnt_id] && !(cnt_after >= MAXC && req_valid[~gnt_id])) begin
              cnt_inc = 1'b1;
            end else begin
              state_nxt = ARB_IDLE;
              cnt_clr   = 1'b1;
            end
          end else begin
            state_nxt = ARB_IDLE;
            cnt_clr   = 1'b1;
          end
        end
        default: begin
          state_nxt = ARB_IDLE;
          cnt_clr   = 1'b1;
        end
      endcase
    end
  end

  assign mem_rd   = |req_grant;
  assign mem_addr = mem_rd ? req_addr[gnt_id] : '0;

  sat_counter #(.MAX(MAX_BURST), .W(CW)) u_burst (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .load  (cnt_load),
    .inc   (cnt_inc),
    .count (burst_cnt)
  );

  pat_tag_pipe #(.DEPTH(LATENCY)) u_tags (
    .clock     (clock),
    .reset     (reset),
    .push      (mem_rd),
    .id_in     (gnt_id),
    .flush     (clear),
    .pop_valid (pop_valid),
    .id_out    (pop_id)
  );

  assign rsp_avail = pop_valid ? (pop_id ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data  = pop_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_pattern_arbiter.sv
// Self-checking bench for pattern_arbiter: directed scenarios plus random
// traffic against a rule-level arbitration and return model.
module tb_pattern_arbiter;
  import pattern_arbiter_pkg::*;

  localparam int L  = 2;
  localparam int MB = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              clear = 1'b0;
  logic [1:0]        req_valid = '0;
  logic [1:0][12:0]  req_addr  = '0;
  logic [1:0]        req_lock  = '0;
  logic [1:0]        req_grant, rsp_avail;
  logic [31:0]       rsp_data;
  logic              mem_rd;
  logic [12:0]       mem_addr;
  logic [31:0]       mem_rdata = '0;

  always #5 clock = ~clock;

  pattern_arbiter #(.LATENCY(L), .MAX_BURST(MB)) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_lock  (req_lock),
    .req_grant (req_grant),
    .rsp_avail (rsp_avail),
    .rsp_data  (rsp_data),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:8191];

  // Model: who holds a lock (-1 none), grants so far in that lock, last winner.
  int owner, run, last;
  logic        want_v [L];
  int          want_id[L];
  logic [12:0] want_a [L];
  // Memory-side delay line driven by what the DUT actually requested.
  logic        mv [L];
  logic [12:0] ma [L];
  logic        cur_rd;
  logic [12:0] cur_addr;
  int          prev_g = -1;
  int          gseq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic int model_grant();
    if (reset || clear)             return -1;
    if (owner >= 0)                 return req_valid[owner] ? owner : -1;
    if (req_valid == 2'b11)         return 1 - last;
    if (req_valid[0])               return 0;
    if (req_valid[1])               return 1;
    return -1;
  endfunction

  task automatic model_reset();
    owner = -1; run = 0; last = 1;
    for (int i = 0; i < L; i++) want_v[i] = 1'b0;
  endtask

  task automatic shift_mem(input logic rd, input logic [12:0] a);
    for (int i = L-1; i > 0; i--) begin mv[i] = mv[i-1]; ma[i] = ma[i-1]; end
    mv[0] = rd; ma[0] = a;
  endtask

  task automatic model_update(input int g);
    for (int i = L-1; i > 0; i--) begin
      want_v[i] = want_v[i-1]; want_id[i] = want_id[i-1]; want_a[i] = want_a[i-1];
    end
    want_v[0]  = (g >= 0);
    want_id[0] = (g >= 0) ? g : 0;
    want_a[0]  = (g >= 0) ? req_addr[g] : '0;
    shift_mem(cur_rd, cur_addr);
    if (clear) begin
      for (int i = 0; i < L; i++) want_v[i] = 1'b0;
      owner = -1; run = 0;
    end else if (g >= 0) begin
      last = g;
      if (owner < 0) begin
        if (req_lock[g]) begin owner = g; run = 1; end
      end else begin
        run = (run + 1 > MB) ? MB : run + 1;
      end
      if (owner >= 0 && (!req_lock[g] || (run >= MB && req_valid[1-g]))) begin
        owner = -1; run = 0;
      end
    end else if (owner >= 0) begin
      owner = -1; run = 0;
    end
  endtask

  // One clock: inputs already driven at posedge+1; check at posedge+4.
  task automatic cycle();
    int g;
    logic [1:0]  eg, ea;
    logic [31:0] ed;
    mem_rdata = mv[L-1] ? mem[ma[L-1]] : $urandom;
    #3;
    g  = model_grant();
    eg = (g < 0) ? 2'b00 : (2'b01 << g);
    ea = (want_v[L-1] && !clear) ? (2'b01 << want_id[L-1]) : 2'b00;
    ed = (ea != 2'b00) ? mem[want_a[L-1]] : 32'h0;
    chk("req_grant", req_grant, eg);
    chk("mem_rd",    mem_rd,    |eg);
    chk("mem_addr",  mem_addr,  (g < 0) ? 13'h0 : req_addr[g]);
    chk("rsp_avail", rsp_avail, ea);
    chk("rsp_data",  rsp_data,  ed);
    cur_rd = mem_rd; cur_addr = mem_addr;
    if (g >= 0) gseq.push_back(g);
    prev_g = g;
    @(posedge clock);
    model_update(g);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, req_grant, 2'b00);
    chk({tag, "_avail"}, rsp_avail, 2'b00);
    chk({tag, "_data"},  rsp_data,  32'h0);
    chk({tag, "_rd"},    mem_rd,    1'b0);
    chk({tag, "_addr"},  mem_addr,  13'h0);
  endtask

  task automatic idle(input int n);
    req_valid = '0; req_lock = '0;
    repeat (n) cycle();
  endtask

  initial begin
    logic [15:0] bits;
    for (int i = 0; i < 8192; i++) mem[i] = $urandom;
    for (int i = 0; i < L; i++) begin mv[i] = 1'b0; ma[i] = '0; end
    model_reset();

    // Reset state
    @(posedge clock); #1;
    req_valid = 2'b11;
    #1 chk_zero("reset");
    req_valid = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    shift_mem(1'b0, '0);

    // Single requester, three back-to-back reads
    req_valid = 2'b01; req_addr[0] = 13'h0123; gseq.delete();
    repeat (3) cycle();
    idle(3);
    chk("single_count", gseq.size(), 3);

    // Round-robin: prime last=1, then both valid six cycles
    req_valid = 2'b10; req_addr[1] = 13'h1abc; cycle();
    req_valid = 2'b11; req_addr[0] = 13'h0040; gseq.delete();
    repeat (6) cycle();
    bits = '0;
    foreach (gseq[i]) bits[i] = gseq[i][0];
    chk("rr_order", {gseq.size(), bits}, {32'd6, 16'b0000_0000_0010_1010});
    idle(3);

    // Lock with contention: four to 0 then one to 1
    req_valid = 2'b11; req_lock = 2'b01; gseq.delete();
    repeat (5) cycle();
    bits = '0;
    foreach (gseq[i]) bits[i] = gseq[i][0];
    chk("burst_limit", {gseq.size(), bits}, {32'd5, 16'b0000_0000_0001_0000});
    // Lock without contention holds indefinitely
    req_valid = 2'b01; gseq.delete();
    repeat (10) cycle();
    chk("lock_hold", {gseq.size(), gseq[0], gseq[9]}, {32'd10, 32'd0, 32'd0});
    idle(3);

    // Clear one cycle after two grants
    req_valid = 2'b01; req_addr[0] = 13'h0777;
    repeat (2) cycle();
    clear = 1'b1; #2 chk("clear_rd", mem_rd, 1'b0); #1;
    cycle();  // cycle() already waited; realign below
    clear = 1'b0;
    gseq.delete();
    idle(3);
    chk("clear_quiet", gseq.size(), 0);
    req_valid = 2'b01; req_addr[0] = 13'h0555; cycle();
    chk("clear_regrant", {gseq.size(), gseq[0]}, {32'd1, 32'd0});
    idle(3);

    // Reset mid-burst in OWN1 with reads in flight
    req_valid = 2'b10; req_lock = 2'b10; req_addr[1] = 13'h0999;
    repeat (3) cycle();
    reset = 1'b1; req_valid = 2'b11;
    mem_rdata = mv[L-1] ? mem[ma[L-1]] : 32'h0;
    #2 chk_zero("rst_mid");
    @(posedge clock); #1;
    chk_zero("rst_held");
    reset = 1'b0; req_lock = '0;
    model_reset();
    shift_mem(1'b0, '0);
    gseq.delete();
    cycle();
    chk("rst_first", {gseq.size(), gseq[0]}, {32'd1, 32'd0});
    idle(3);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [1:0] nv;
      nv = 2'($urandom);
      for (int i = 0; i < 2; i++)
        if (!req_valid[i] || prev_g == i) req_addr[i] = 13'($urandom);
      req_valid = nv;
      req_lock  = 2'($urandom);
      clear     = ($urandom_range(0, 15) == 0);
      cycle();
    end
    clear = 1'b0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
